avg_unpool_stream: RTL
======================

Name: avg_unpool_stream

Overview:
- Streaming backward/inverse counterpart of the 2x2 average-pooling layer in the FP16 LeNet datapath.
- Accepts a pooled feature map (Depth x outH/2 x outW/2) as a valid/ready stream of FP16 values and emits the upsampled map (Depth x outH x outW).
- Each pooled value is replicated into its 2x2 window and, optionally, scaled by 0.25 to give the average-pool gradient.
- Sits between a gradient/feature source and the next upsampled consumer; one pooled row is buffered internally.

Parameters:
DATA_WIDTH, 16, element width; fixed FP16 (1/5/10) when scaling is compiled in
Depth, 6, number of channels per frame
outH, 28, output map height; must be even
outW, 28, output map width; must be even

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
in_data  in  DATA_WIDTH  pooled value; raster order, channel-major (ch, row, col)
in_valid  in  1  in_data valid
in_ready  out  1  block can accept in_data this cycle
out_data  out  DATA_WIDTH  upsampled value; raster order, channel-major
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts out_data
out_last  out  1  high with the final element of a frame (ch=Depth-1, row=outH-1, col=outW-1)

Behaviour:
- Reset (async assert, synchronous release): out_valid=0, out_data=0, out_last=0, in_ready=0 during reset. State=ROW_A. Channel, row, col and dup counters=0. Row buffer contents are not reset; they are don't-care.
- Handshake: a transfer occurs on a side when valid&&ready are both high at a rising edge. out_data, out_valid and out_last are registered and hold stable while out_valid=1 and out_ready=0. in_ready has no combinational dependence on in_valid.
- Counters:
  - pcol counts 0..outW/2-1.
  - dup counts 0..1 and selects the horizontal copy.
  - prow counts 0..outH/2-1.
  - ch counts 0..Depth-1.
- State ROW_A (emits output row 2*prow):
  - in_ready = !out_valid || (out_ready && dup==1).
  - On input accept: scaled value goes to out_data, out_valid=1 and dup=0 next cycle. The raw value is written to buf[pcol].
  - On output accept with dup==0: dup becomes 1 and the same data is re-presented.
  - On output accept with dup==1: pcol increments.
  - After the dup==1 accept at pcol=outW/2-1: go to ROW_B, pcol=0.
- State ROW_B (emits output row 2*prow+1):
  - in_ready=0.
  - Each buf[pcol] is emitted twice, scaled identically, one element per cycle when out_ready=1.
  - After the last element: prow increments and state returns to ROW_A.
  - Wrap order: prow wraps at outH/2 and increments ch; ch wraps at Depth, starting a new frame.
- Latency and throughput:
  - First out_valid occurs 1 cycle after the first input accept.
  - Sustained rate is 1 output per cycle with out_ready held high.
  - Input rate is at most 1 value per 2 cycles in ROW_A and 0 in ROW_B.
- out_last is asserted only with the second copy of the buffered last pooled value in ROW_B of the last prow of the last channel.
- Simultaneous output accept (dup==1) and input accept in ROW_A: the new value loads the same cycle with no bubble.
- Reset mid-operation: the partial frame is discarded; the next accepted input is treated as ch=0, prow=0, pcol=0.
- Storage: buffer is outW/2 x DATA_WIDTH.

Optional Feature:
- Macro UNPOOL_GRAD_SCALE_EN defined: every output is the input multiplied by 0.25 in FP16, with truncation, no rounding. Let e = exponent field.
  - e>=3 and e<31: e-2, mantissa unchanged.
  - e in {1,2}: result is subnormal with exponent 0 and fraction = {1,mant} >> (3-e).
  - e==0 (zero/subnormal): fraction >> 2.
  - e==31 (Inf/NaN): passed unchanged.
  - The sign bit is always preserved.
- Macro undefined: out_data equals the stored input bit-for-bit (pure nearest-neighbour upsampling, any DATA_WIDTH).

Test Plan:
- Depth=1, outH=4, outW=4, no scaling, inputs 0x3C00,0x4000,0x4200,0x4400, out_ready=1 -> 16 outputs in rows [3C00 3C00 4000 4000]x2, then [4200 4200 4400 4400]x2. out_last only on the 16th output. First output 1 cycle after the first accept.
- UNPOOL_GRAD_SCALE_EN, inputs 0x3C00, 0xBC00, 0x7C00, 0x0400 -> outputs (each x4) 0x3400, 0xB400, 0x7C00, 0x0100.
- UNPOOL_GRAD_SCALE_EN, inputs 0x0800 (e=2) and 0x0003 (subnormal) -> outputs 0x0200 and 0x0000.
- Random out_ready (50%) and random in_valid over a Depth=2 frame -> output sequence identical to the ready=1 case. out_data stable whenever stalled. No input accepted while in ROW_B.
- Assert reset after 5 outputs of row 0, then replay a full frame -> out_valid=0 immediately on reset. The post-reset frame is correct, with out_last on element Depth*outH*outW.
- Two back-to-back frames, Depth=6, outH=outW=28 -> 4704 outputs per frame. out_last is pulsed twice. in_ready stays high at the frame boundary without extra bubbles.

Source files
------------

// File: rtl/avg_unpool_stream_if.sv
// Stream bundle for avg_unpool_stream: pooled values in, upsampled values out.
// slave = the unpooling block, master = the surrounding source/sink.
interface avg_unpool_stream_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/avg_unpool_stream.sv
// 2x2 average-unpooling stream: each pooled value is replicated into its 2x2 window.
// Define UNPOOL_GRAD_SCALE_EN to scale every output by 0.25 (FP16, truncating).
//
// state | meaning
// ROW_A | take pooled values, emit each twice (even output row), store raw value in row buffer
// ROW_B | replay the row buffer, each value twice (odd output row); input stalled
module avg_unpool_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int Depth      = 6,
  parameter int outH       = 28,
  parameter int outW       = 28
) (
  input  logic                 clk,
  input  logic                 reset,
  avg_unpool_stream_if.slave   strm
);

  localparam int PW  = outW / 2;
  localparam int PH  = outH / 2;
  localparam int PCW = (PW > 1) ? $clog2(PW) : 1;
  localparam int PRW = (PH > 1) ? $clog2(PH) : 1;
  localparam int CHW = (Depth > 1) ? $clog2(Depth) : 1;

  typedef enum logic {ROW_A, ROW_B} state_t;

  state_t                state_q, state_d;
  logic [PCW-1:0]        pcol_q;
  logic [PRW-1:0]        prow_q;
  logic [CHW-1:0]        ch_q;
  logic                  dup_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_valid_q;
  logic                  out_last_q;
  logic [DATA_WIDTH-1:0] row_buf [PW];

  logic [1:0]            rst_sync;
  logic                  rst_int;
  logic                  in_rdy;
  logic                  in_acc;
  logic                  out_acc;
  logic                  pcol_last;
  logic                  prow_last;
  logic                  ch_last;
  logic [PCW-1:0]        wr_col;

  function automatic logic [DATA_WIDTH-1:0] scale(input logic [DATA_WIDTH-1:0] x);
`ifdef UNPOOL_GRAD_SCALE_EN
    logic [4:0]            e;
    logic [10:0]           sig;
    logic [DATA_WIDTH-1:0] r;
    e   = x[14:10];
    sig = {1'b1, x[9:0]};
    r   = x;
    if (e == 5'd31) begin
      r = x;
    end else if (e >= 5'd3) begin
      r[14:10] = e - 5'd2;
    end else if (e == 5'd2) begin
      r[14:10] = 5'd0;
      r[9:0]   = sig[10:1];
    end else if (e == 5'd1) begin
      r[14:10] = 5'd0;
      r[9:0]   = {1'b0, sig[10:2]};
    end else begin
      r[9:0]   = {2'b00, x[9:2]};
    end
    return r;
`else
    return x;
`endif
  endfunction

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rst_sync <= 2'b11;
    else       rst_sync <= {rst_sync[0], 1'b0};
  end
  assign rst_int = rst_sync[1];

  assign pcol_last = (pcol_q == PCW'(PW - 1));
  assign prow_last = (prow_q == PRW'(PH - 1));
  assign ch_last   = (ch_q == CHW'(Depth - 1));
  assign out_acc   = out_valid_q && strm.out_ready;
  assign in_acc    = strm.in_valid && in_rdy;
  // A load that overlaps the second-copy accept belongs to the next column.
  assign wr_col    = out_valid_q ? PCW'(pcol_q + 1'b1) : pcol_q;

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) state_q <= ROW_A;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    in_rdy  = 1'b0;
    case (state_q)
      ROW_A: begin
        // Never take a value once the row's last column is presented; the next one belongs after ROW_B.
        in_rdy = !rst_int && (!out_valid_q || (strm.out_ready && dup_q && !pcol_last));
        if (out_acc && dup_q && pcol_last) state_d = ROW_B;
      end
      ROW_B: begin
        if (out_acc && dup_q && pcol_last) state_d = ROW_A;
      end
      default: state_d = ROW_A;
    endcase
  end

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      pcol_q      <= '0;
      prow_q      <= '0;
      ch_q        <= '0;
      dup_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        ROW_A: begin
          if (out_acc) begin
            if (!dup_q) begin
              dup_q <= 1'b1;
            end else if (pcol_last) begin
              pcol_q      <= '0;
              dup_q       <= 1'b0;
              out_data_q  <= scale(row_buf[0]);
              out_valid_q <= 1'b1;
              out_last_q  <= 1'b0;
            end else begin
              pcol_q      <= PCW'(pcol_q + 1'b1);
              dup_q       <= 1'b0;
              out_valid_q <= 1'b0;
            end
          end
          if (in_acc) begin
            pcol_q      <= wr_col;
            dup_q       <= 1'b0;
            out_data_q  <= scale(strm.in_data);
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
          end
        end
        ROW_B: begin
          if (out_acc) begin
            if (!dup_q) begin
              dup_q      <= 1'b1;
              out_last_q <= pcol_last && prow_last && ch_last;
            end else if (pcol_last) begin
              pcol_q      <= '0;
              dup_q       <= 1'b0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              if (prow_last) begin
                prow_q <= '0;
                ch_q   <= ch_last ? '0 : CHW'(ch_q + 1'b1);
              end else begin
                prow_q <= PRW'(prow_q + 1'b1);
              end
            end else begin
              pcol_q     <= PCW'(pcol_q + 1'b1);
              dup_q      <= 1'b0;
              out_data_q <= scale(row_buf[PCW'(pcol_q + 1'b1)]);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Row buffer holds raw values; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (in_acc) row_buf[wr_col] <= strm.in_data;
  end

  assign strm.in_ready  = in_rdy;
  assign strm.out_data  = out_data_q;
  assign strm.out_valid = out_valid_q;
  assign strm.out_last  = out_last_q;

endmodule
